// File: rtl/enigma_scrambler_pkg.sv
// Shared constants for the ENIGMA551 scrambler: alphabet size, wiring tables
// for rotors I/II/III (forward and inverse), reflector B, and mod-26 helpers.
package enigma_pkg;

    localparam int ALPHA        = 26;
    localparam int LATENCY_BASE = 7;

    typedef logic [4:0] letter_t;

    typedef enum logic [1:0] {
        ROT_I   = 2'd0,
        ROT_II  = 2'd1,
        ROT_III = 2'd2
    } rotor_e;

    typedef struct packed {
        logic    valid;
        letter_t letter;
        letter_t p1;
        letter_t p2;
        letter_t p3;
        logic    err;
    } stage_t;

    localparam letter_t W_I [ALPHA] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam letter_t W_II [ALPHA] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
        5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam letter_t W_III [ALPHA] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam letter_t WINV_I [ALPHA] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
        5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
    localparam letter_t WINV_II [ALPHA] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
        5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
    localparam letter_t WINV_III [ALPHA] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
        5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
    localparam letter_t REF_B [ALPHA] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23, 5'd13, 5'd6,  5'd14,
        5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};

    function automatic logic is_legal(letter_t x);
        return x < 5'(ALPHA);
    endfunction

    function automatic letter_t add_mod26(letter_t a, letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
        return s[4:0];
    endfunction

    // a - b + 26 never underflows for legal operands, so one conditional subtract suffices
    function automatic letter_t sub_mod26(letter_t a, letter_t b);
        logic [5:0] d;
        d = {1'b0, a} - {1'b0, b} + 6'(ALPHA);
        if (d >= 6'(ALPHA)) d = d - 6'(ALPHA);
        return d[4:0];
    endfunction

    function automatic letter_t rotor_map(rotor_e sel, logic inv, letter_t idx);
        letter_t r;
        r = '0;
        if (is_legal(idx)) begin
            case (sel)
                ROT_I:   r = inv ? WINV_I[idx]   : W_I[idx];
                ROT_II:  r = inv ? WINV_II[idx]  : W_II[idx];
                ROT_III: r = inv ? WINV_III[idx] : W_III[idx];
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic letter_t reflect_b(letter_t idx);
        return is_legal(idx) ? REF_B[idx] : '0;
    endfunction

endpackage

// File: rtl/enigma_scrambler_if.sv
// Letter stream handshake plus plugboard write port between the stepping stage
// (master) and the scrambler (slave).
interface enigma_scrambler_if;
    import enigma_pkg::*;

    logic    in_valid;
    logic    in_ready;
    letter_t in_letter;
    letter_t rotor1_pos;
    letter_t rotor2_pos;
    letter_t rotor3_pos;
    logic    out_valid;
    logic    out_ready;
    letter_t out_letter;
    logic    out_err;
    logic    pb_wr;
    letter_t pb_addr;
    letter_t pb_data;

    modport master (
        output in_valid, in_letter, rotor1_pos, rotor2_pos, rotor3_pos, out_ready,
               pb_wr, pb_addr, pb_data,
        input  in_ready, out_valid, out_letter, out_err
    );

    modport slave (
        input  in_valid, in_letter, rotor1_pos, rotor2_pos, rotor3_pos, out_ready,
               pb_wr, pb_addr, pb_data,
        output in_ready, out_valid, out_letter, out_err
    );

endinterface

// File: rtl/enigma_scrambler_rotor_stage.sv
// One registered rotor substitution (forward or inverse); the wiring select
// also picks which of the three carried positions applies.
module rotor_stage
    import enigma_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_adv,
    input  rotor_e i_sel,
    input  logic   i_inv,
    input  stage_t i_stage,
    output stage_t o_stage
);

    letter_t w_pos;
    letter_t w_idx;
    letter_t w_map;
    stage_t  w_next;
    stage_t  r_stage;

    always_comb begin
        case (i_sel)
            ROT_III: w_pos = i_stage.p1;
            ROT_II:  w_pos = i_stage.p2;
            ROT_I:   w_pos = i_stage.p3;
            default: w_pos = i_stage.p1;
        endcase
        w_idx  = add_mod26(i_stage.letter, w_pos);
        w_map  = rotor_map(i_sel, i_inv, w_idx);
        w_next = i_stage;
        // errored letters ride through untouched
        if (!i_stage.err) w_next.letter = sub_mod26(w_map, w_pos);
    end

    always_ff @(posedge clk) begin
        if (rst)        r_stage <= '0;
        else if (i_adv) r_stage <= w_next;
    end

    assign o_stage = r_stage;

endmodule

// File: rtl/enigma_scrambler.sv
// ENIGMA551 scrambler pipeline: F1 F2 F3 RF B3 B2 B1 under a global stall.
// Define PLUGBOARD_EN to add the plugboard table and its PI/PO lookup stages.
module enigma_scrambler
    import enigma_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    enigma_scrambler_if.slave bus
);

    logic   w_adv;
    stage_t w_acc;
    stage_t w_f1_in;
    stage_t w_f1, w_f2, w_f3;
    stage_t w_rf_next;
    stage_t r_rf;
    stage_t w_b3, w_b2, w_b1;
    stage_t w_last;

    assign w_adv        = !w_last.valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    always_comb begin
        w_acc.valid  = bus.in_valid;
        w_acc.letter = bus.in_letter;
        w_acc.p1     = bus.rotor1_pos;
        w_acc.p2     = bus.rotor2_pos;
        w_acc.p3     = bus.rotor3_pos;
        w_acc.err    = !(is_legal(bus.in_letter) && is_legal(bus.rotor1_pos) &&
                         is_legal(bus.rotor2_pos) && is_legal(bus.rotor3_pos));
    end

`ifdef PLUGBOARD_EN
    letter_t r_pb [ALPHA];
    stage_t  w_pi_next, r_pi;
    stage_t  w_po_next, r_po;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ALPHA; i++) r_pb[i] <= letter_t'(i);
        end else if (bus.pb_wr && is_legal(bus.pb_addr)) begin
            r_pb[bus.pb_addr] <= bus.pb_data;
        end
    end

    always_comb begin
        w_pi_next = w_acc;
        if (!w_acc.err) w_pi_next.letter = r_pb[w_acc.letter];
        w_po_next = w_b1;
        if (!w_b1.err && is_legal(w_b1.letter)) w_po_next.letter = r_pb[w_b1.letter];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pi <= '0;
            r_po <= '0;
        end else if (w_adv) begin
            r_pi <= w_pi_next;
            r_po <= w_po_next;
        end
    end

    assign w_f1_in = r_pi;
    assign w_last  = r_po;
`else
    logic w_pb_unused;
    assign w_pb_unused = ^{bus.pb_wr, bus.pb_addr, bus.pb_data};
    assign w_f1_in     = w_acc;
    assign w_last      = w_b1;
`endif

    rotor_stage u_f1 (.clk(clk), .rst(rst), .i_adv(w_adv), .i_sel(ROT_III), .i_inv(1'b0),
                      .i_stage(w_f1_in), .o_stage(w_f1));
    rotor_stage u_f2 (.clk(clk), .rst(rst), .i_adv(w_adv), .i_sel(ROT_II), .i_inv(1'b0),
                      .i_stage(w_f1), .o_stage(w_f2));
    rotor_stage u_f3 (.clk(clk), .rst(rst), .i_adv(w_adv), .i_sel(ROT_I), .i_inv(1'b0),
                      .i_stage(w_f2), .o_stage(w_f3));

    always_comb begin
        w_rf_next = w_f3;
        if (!w_f3.err) w_rf_next.letter = reflect_b(w_f3.letter);
    end

    always_ff @(posedge clk) begin
        if (rst)        r_rf <= '0;
        else if (w_adv) r_rf <= w_rf_next;
    end

    rotor_stage u_b3 (.clk(clk), .rst(rst), .i_adv(w_adv), .i_sel(ROT_I), .i_inv(1'b1),
                      .i_stage(r_rf), .o_stage(w_b3));
    rotor_stage u_b2 (.clk(clk), .rst(rst), .i_adv(w_adv), .i_sel(ROT_II), .i_inv(1'b1),
                      .i_stage(w_b3), .o_stage(w_b2));
    rotor_stage u_b1 (.clk(clk), .rst(rst), .i_adv(w_adv), .i_sel(ROT_III), .i_inv(1'b1),
                      .i_stage(w_b2), .o_stage(w_b1));

    assign bus.out_valid  = w_last.valid;
    assign bus.out_letter = w_last.letter;
    assign bus.out_err    = w_last.err;

endmodule

// File: tb/tb_enigma_scrambler.sv
// Self-checking bench for enigma_scrambler: random streams checked against a
// string-table Enigma model, plus directed reset, stall and error scenarios.
module tb_enigma_scrambler;
    import enigma_pkg::*;

`ifdef PLUGBOARD_EN
    localparam int LAT = LATENCY_BASE + 2;
`else
    localparam int LAT = LATENCY_BASE;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    enigma_scrambler_if bus ();
    enigma_scrambler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    string ROT_FAST = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    string ROT_MID  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    string ROT_SLOW = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    string REFL     = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    int    pb_model [26];

    int stim_l[$], stim_p1[$], stim_p2[$], stim_p3[$];
    int got_l[$], got_e[$], got_cyc[$], acc_cyc[$];
    int hold_viol;
    bit saw_inready_low;

    function automatic int rot(string w, int c, int p, bit inv);
        int i, v;
        i = (c + p) % 26;
        v = 0;
        if (!inv) v = int'(w[i]) - 65;
        else for (int j = 0; j < 26; j++) if (int'(w[j]) - 65 == i) v = j;
        return (v - p + 26) % 26;
    endfunction

    function automatic int model(int c, int p1, int p2, int p3);
        int x;
        if (c > 25 || p1 > 25 || p2 > 25 || p3 > 25) return c;
`ifdef PLUGBOARD_EN
        x = pb_model[c];
`else
        x = c;
`endif
        x = rot(ROT_FAST, x, p1, 0);
        x = rot(ROT_MID,  x, p2, 0);
        x = rot(ROT_SLOW, x, p3, 0);
        x = int'(REFL[x]) - 65;
        x = rot(ROT_SLOW, x, p3, 1);
        x = rot(ROT_MID,  x, p2, 1);
        x = rot(ROT_FAST, x, p1, 1);
`ifdef PLUGBOARD_EN
        x = pb_model[x];
`endif
        return x;
    endfunction

    task automatic clear_stim();
        stim_l.delete(); stim_p1.delete(); stim_p2.delete(); stim_p3.delete();
    endtask

    task automatic push_stim(input int l, input int p1, input int p2, input int p3);
        stim_l.push_back(l); stim_p1.push_back(p1); stim_p2.push_back(p2); stim_p3.push_back(p3);
    endtask

    // Drives the stim queues and records what comes out; entered/left #1 after a posedge.
    // ready_mode: 0 always ready, 1 five-cycle stall after ten letters, 2 random.
    task automatic run_stream(input int ready_mode, input int budget);
        int sent = 0;
        bit prev_stall = 0;
        int prev_l = 0, prev_e = 0;
        got_l.delete(); got_e.delete(); got_cyc.delete(); acc_cyc.delete();
        hold_viol = 0;
        saw_inready_low = 0;
        for (int k = 0; k < budget && (sent < stim_l.size() || got_l.size() < stim_l.size()); k++) begin
            if (sent < stim_l.size()) begin
                bus.in_valid   = 1'b1;
                bus.in_letter  = 5'(stim_l[sent]);
                bus.rotor1_pos = 5'(stim_p1[sent]);
                bus.rotor2_pos = 5'(stim_p2[sent]);
                bus.rotor3_pos = 5'(stim_p3[sent]);
            end else begin
                bus.in_valid = 1'b0;
            end
            case (ready_mode)
                1:       bus.out_ready = !(k >= 10 && k <= 14);
                2:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b1;
            endcase
            #1;
            if (prev_stall && (!bus.out_valid || int'(bus.out_letter) != prev_l ||
                               int'(bus.out_err) != prev_e)) hold_viol++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_l     = int'(bus.out_letter);
            prev_e     = int'(bus.out_err);
            if (!bus.in_ready) saw_inready_low = 1;
            if (bus.out_valid && bus.out_ready) begin
                got_l.push_back(int'(bus.out_letter));
                got_e.push_back(int'(bus.out_err));
                got_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc.push_back(cyc);
                sent++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 0; bus.in_letter = 0; bus.rotor1_pos = 0; bus.rotor2_pos = 0;
        bus.rotor3_pos = 0; bus.out_ready = 0; bus.pb_wr = 0; bus.pb_addr = 0; bus.pb_data = 0;
        for (int i = 0; i < 26; i++) pb_model[i] = i;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_letter !== 5'd0) begin n_err++; $display("FAIL reset_out_letter got %0d expected 0", bus.out_letter); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err got %0b expected 0", bus.out_err); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b expected 1", bus.in_ready); end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known_vector();
        int exp_l [5] = '{1, 3, 25, 6, 14};
        clear_stim();
        for (int i = 0; i < 5; i++) push_stim(0, i + 1, 0, 0);
        run_stream(0, 60);
        n_cmp++; if (got_l.size() != 5) begin n_err++; $display("FAIL known_count got %0d expected 5", got_l.size()); end
        for (int i = 0; i < 5 && i < got_l.size(); i++) begin
            n_cmp++;
            if (got_l[i] != exp_l[i]) begin n_err++; $display("FAIL known_letter[%0d] got %0d expected %0d", i, got_l[i], exp_l[i]); end
            n_cmp++;
            if (got_cyc[i] - acc_cyc[i] != LAT) begin
                n_err++; $display("FAIL known_latency[%0d] got %0d expected %0d", i, got_cyc[i] - acc_cyc[i], LAT);
            end
        end
    endtask

    task automatic test_reciprocity();
        int first_out [26];
        clear_stim();
        push_stim(1, 1, 0, 0);
        run_stream(0, 40);
        n_cmp++; if (got_l.size() != 1 || got_l[0] != 0) begin
            n_err++; $display("FAIL recip_B_at_100 got %0d (count %0d) expected 0", got_l.size() > 0 ? got_l[0] : -1, got_l.size());
        end
        clear_stim();
        for (int i = 0; i < 26; i++) push_stim(i, 7, 13, 20);
        run_stream(0, 80);
        n_cmp++; if (got_l.size() != 26) begin n_err++; $display("FAIL sweep_count got %0d expected 26", got_l.size()); end
        for (int i = 0; i < 26; i++) begin
            first_out[i] = (i < got_l.size()) ? got_l[i] : -1;
            n_cmp++; if (first_out[i] == i) begin n_err++; $display("FAIL sweep_fixed_point[%0d] got %0d expected different", i, first_out[i]); end
            n_cmp++; if (first_out[i] != model(i, 7, 13, 20)) begin
                n_err++; $display("FAIL sweep_model[%0d] got %0d expected %0d", i, first_out[i], model(i, 7, 13, 20));
            end
        end
        clear_stim();
        for (int i = 0; i < 26; i++) push_stim(first_out[i] < 0 ? 0 : first_out[i], 7, 13, 20);
        run_stream(0, 80);
        for (int i = 0; i < 26; i++) begin
            n_cmp++;
            if (i >= got_l.size() || got_l[i] != i) begin
                n_err++; $display("FAIL sweep_reencrypt[%0d] got %0d expected %0d", i, i < got_l.size() ? got_l[i] : -1, i);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_stim();
        for (int i = 0; i < 10; i++)
            push_stim($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
        run_stream(1, 80);
        n_cmp++; if (got_l.size() != 10) begin n_err++; $display("FAIL bp_count got %0d expected 10", got_l.size()); end
        for (int i = 0; i < 10 && i < got_l.size(); i++) begin
            n_cmp++;
            if (got_l[i] != model(stim_l[i], stim_p1[i], stim_p2[i], stim_p3[i])) begin
                n_err++; $display("FAIL bp_order[%0d] got %0d expected %0d", i, got_l[i], model(stim_l[i], stim_p1[i], stim_p2[i], stim_p3[i]));
            end
        end
        n_cmp++; if (hold_viol != 0) begin n_err++; $display("FAIL bp_hold_stable got %0d changes expected 0", hold_viol); end
        n_cmp++; if (!saw_inready_low) begin n_err++; $display("FAIL bp_in_ready_fall got never-low expected low"); end
    endtask

    task automatic test_illegal();
        clear_stim();
        push_stim(27, 1, 0, 0);
        push_stim(5, 0, 30, 0);
        push_stim(5, 0, 3, 0);
        run_stream(0, 40);
        n_cmp++; if (got_l.size() != 3) begin n_err++; $display("FAIL illegal_count got %0d expected 3", got_l.size()); end
        if (got_l.size() == 3) begin
            n_cmp++; if (got_l[0] != 27 || got_e[0] != 1) begin n_err++; $display("FAIL illegal_letter got %0d err %0d expected 27 err 1", got_l[0], got_e[0]); end
            n_cmp++; if (got_l[1] != 5 || got_e[1] != 1) begin n_err++; $display("FAIL illegal_pos got %0d err %0d expected 5 err 1", got_l[1], got_e[1]); end
            n_cmp++; if (got_l[2] != model(5, 0, 3, 0) || got_e[2] != 0) begin
                n_err++; $display("FAIL legal_after_err got %0d err %0d expected %0d err 0", got_l[2], got_e[2], model(5, 0, 3, 0));
            end
        end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_letter = 5'(i + 3);
            bus.rotor1_pos = 5'(i); bus.rotor2_pos = 5'd2; bus.rotor3_pos = 5'd9;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 26; i++) pb_model[i] = i;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %0b expected 1", bus.in_ready); end
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) stale++;
            @(posedge clk); #1;
        end
        n_cmp++; if (stale != 0) begin n_err++; $display("FAIL midrst_stale got %0d outputs expected 0", stale); end
    endtask

    task automatic test_random_stream();
        int l, p1, p2, p3, e;
        clear_stim();
        for (int i = 0; i < 40; i++) begin
            l = $urandom_range(0, 25); p1 = $urandom_range(0, 25);
            p2 = $urandom_range(0, 25); p3 = $urandom_range(0, 25);
            if ($urandom_range(0, 7) == 0) l = $urandom_range(26, 31);
            if ($urandom_range(0, 9) == 0) p3 = $urandom_range(26, 31);
            push_stim(l, p1, p2, p3);
        end
        run_stream(2, 600);
        n_cmp++; if (got_l.size() != 40) begin n_err++; $display("FAIL rand_count got %0d expected 40", got_l.size()); end
        for (int i = 0; i < 40 && i < got_l.size(); i++) begin
            e = (stim_l[i] > 25 || stim_p1[i] > 25 || stim_p2[i] > 25 || stim_p3[i] > 25) ? 1 : 0;
            n_cmp++;
            if (got_l[i] != model(stim_l[i], stim_p1[i], stim_p2[i], stim_p3[i]) || got_e[i] != e) begin
                n_err++; $display("FAIL rand[%0d] got %0d err %0d expected %0d err %0d", i, got_l[i], got_e[i],
                                  model(stim_l[i], stim_p1[i], stim_p2[i], stim_p3[i]), e);
            end
        end
        n_cmp++; if (hold_viol != 0) begin n_err++; $display("FAIL rand_hold_stable got %0d changes expected 0", hold_viol); end
    endtask

`ifdef PLUGBOARD_EN
    task automatic test_plugboard();
        int wa [4] = '{0, 4, 1, 2};
        int wd [4] = '{4, 0, 2, 1};
        for (int i = 0; i < 4; i++) begin
            bus.pb_wr = 1'b1; bus.pb_addr = 5'(wa[i]); bus.pb_data = 5'(wd[i]);
            pb_model[wa[i]] = wd[i];
            @(posedge clk); #1;
        end
        bus.pb_wr = 1'b0;
        clear_stim();
        push_stim(4, 1, 0, 0);
        run_stream(0, 40);
        n_cmp++; if (got_l.size() != 1 || got_l[0] != 2) begin
            n_err++; $display("FAIL pb_letter got %0d (count %0d) expected 2", got_l.size() > 0 ? got_l[0] : -1, got_l.size());
        end
        n_cmp++; if (got_l.size() != 1 || got_cyc[0] - acc_cyc[0] != 9) begin
            n_err++; $display("FAIL pb_latency got %0d expected 9", got_l.size() > 0 ? got_cyc[0] - acc_cyc[0] : -1);
        end
        clear_stim();
        for (int i = 0; i < 12; i++)
            push_stim($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
        run_stream(2, 300);
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (i >= got_l.size() || got_l[i] != model(stim_l[i], stim_p1[i], stim_p2[i], stim_p3[i])) begin
                n_err++; $display("FAIL pb_rand[%0d] got %0d expected %0d", i, i < got_l.size() ? got_l[i] : -1,
                                  model(stim_l[i], stim_p1[i], stim_p2[i], stim_p3[i]));
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_vector();
        test_reciprocity();
        test_backpressure();
        test_illegal();
        test_random_stream();
        test_reset_midstream();
`ifdef PLUGBOARD_EN
        test_plugboard();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
